// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file writeback controller.
//   state_t  : mode FSM states
//   MODE_SVC : mode presented after reset (supervisor)
//   PC_IDX   : register address that aliases the program counter
package regfile_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, SWITCH} state_t;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam int         PC_IDX   = 15;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, async active-high reset
//   req[1:0] : requests (0 = ALU, 1 = LSU)
//   take     : the granted request was actually transferred this cycle
//   gnt[1:0] : one-hot grant (combinational)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);
  // pri=0 favours requester 0, pri=1 favours requester 1
  logic pri;

  always_comb begin
    gnt[0] = req[0] && (!req[1] || !pri);
    gnt[1] = req[1] && (!req[0] ||  pri);
  end

  // A grant that loses downstream (PC port) does not count as served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pri <= 1'b0;
    else if (take) pri <= gnt[0];
  end
endmodule

// File: rtl/regfile_ctrl.sv
// Register-file writeback controller: merges ALU/LSU writebacks onto one
// GPR port (round-robin), routes PC-aliased writes and branches onto the
// PC port, tracks pending destinations in a busy scoreboard and sequences
// processor-mode changes once all pending writes have drained.
//   alu_* / lsu_* / br_* : writeback requesters (req/ready handshakes)
//   claim_*              : destination reservation from issue
//   mode_req/new/ack     : mode-change handshake
//   w_addr/w_data/write_reg, pc_data/write_pc : registered write ports
//   M, busy, claim_err   : mode, scoreboard, sticky double-claim flag
module regfile_ctrl import regfile_ctrl_pkg::*; #(
  parameter int AW     = 4,
  parameter int DW     = 32,
  parameter int MW     = 5,
  parameter int PC_IDX = regfile_ctrl_pkg::PC_IDX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_req,
  input  logic [AW-1:0]     alu_addr,
  input  logic [DW-1:0]     alu_data,
  output logic              alu_ready,
  input  logic              lsu_req,
  input  logic [AW-1:0]     lsu_addr,
  input  logic [DW-1:0]     lsu_data,
  output logic              lsu_ready,
  input  logic              br_req,
  input  logic [DW-1:0]     br_data,
  output logic              br_ready,
  input  logic              claim_valid,
  input  logic [AW-1:0]     claim_addr,
  output logic              claim_ready,
  input  logic              mode_req,
  input  logic [MW-1:0]     mode_new,
  output logic              mode_ack,
  output logic [AW-1:0]     w_addr,
  output logic [DW-1:0]     w_data,
  output logic              write_reg,
  output logic              write_pc,
  output logic [DW-1:0]     pc_data,
  output logic [MW-1:0]     M,
  output logic [(1<<AW)-1:0] busy,
  output logic              claim_err
);
  state_t          state;
  logic [MW-1:0]   mode_lat;
  logic [1:0]      gnt;
  logic            take, win_pc, claim_ok;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic [(1<<AW)-1:0] busy_nxt;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({lsu_req, alu_req}),
    .take (take),
    .gnt  (gnt)
  );

  always_comb begin
    win_addr = gnt[1] ? lsu_addr : alu_addr;
    win_data = gnt[1] ? lsu_data : alu_data;
    win_pc   = (win_addr == AW'(PC_IDX));
    // branch owns the PC port; a PC-targeted GPR winner waits behind it
    take     = (|gnt) && !(win_pc && br_req);
  end

  assign alu_ready   = gnt[0] && take;
  assign lsu_ready   = gnt[1] && take;
  assign br_ready    = br_req;
  assign claim_ready = (state == IDLE);
  assign claim_ok    = claim_valid && claim_ready;

  // Clear before set so a same-cycle claim of a committing register stays busy.
  always_comb begin
    busy_nxt = busy;
    if (take)     busy_nxt[win_addr]   = 1'b0;
    if (claim_ok) busy_nxt[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_reg <= 1'b0;
      write_pc  <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
      pc_data   <= '0;
      busy      <= '0;
      claim_err <= 1'b0;
    end else begin
      write_reg <= take && !win_pc;
      write_pc  <= br_req || (take && win_pc);
      if (take && !win_pc) begin
        w_addr <= win_addr;
        w_data <= win_data;
      end
      if (br_req)              pc_data <= br_data;
      else if (take && win_pc) pc_data <= win_data;
      busy <= busy_nxt;
      if (claim_ok && busy[claim_addr]) claim_err <= 1'b1;
    end
  end

  // Mode FSM; M and mode_ack update on entry to SWITCH so the ack is
  // visible for exactly the one SWITCH cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      M        <= MW'(MODE_SVC);
      mode_lat <= MW'(MODE_SVC);
      mode_ack <= 1'b0;
    end else begin
      mode_ack <= 1'b0;
      case (state)
        IDLE: if (mode_req) begin
          state    <= DRAIN;
          mode_lat <= mode_new;
        end
        DRAIN: if (busy == '0 && !write_reg && !write_pc) begin
          state    <= SWITCH;
          M        <= mode_lat;
          mode_ack <= 1'b1;
        end
        SWITCH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_ctrl.sv
module tb_regfile_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_req, lsu_req, br_req, claim_valid, mode_req;
  logic [3:0]  alu_addr, lsu_addr, claim_addr;
  logic [31:0] alu_data, lsu_data, br_data;
  logic [4:0]  mode_new;
  logic        alu_ready, lsu_ready, br_ready, claim_ready, mode_ack;
  logic [3:0]  w_addr;
  logic [31:0] w_data, pc_data;
  logic        write_reg, write_pc, claim_err;
  logic [4:0]  M;
  logic [15:0] busy;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_ctrl dut (
    .clk(clk), .rst(rst),
    .alu_req(alu_req), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .br_req(br_req), .br_data(br_data), .br_ready(br_ready),
    .claim_valid(claim_valid), .claim_addr(claim_addr), .claim_ready(claim_ready),
    .mode_req(mode_req), .mode_new(mode_new), .mode_ack(mode_ack),
    .w_addr(w_addr), .w_data(w_data), .write_reg(write_reg), .write_pc(write_pc),
    .pc_data(pc_data), .M(M), .busy(busy), .claim_err(claim_err)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    alu_req = 0; lsu_req = 0; br_req = 0; claim_valid = 0; mode_req = 0;
    alu_addr = 0; lsu_addr = 0; claim_addr = 0; alu_data = 0; lsu_data = 0;
    br_data = 0; mode_new = 0;
    #3;
    tests++; if ({write_reg, write_pc, mode_ack, claim_err} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b want 0000", {write_reg, write_pc, mode_ack, claim_err}); end
    tests++; if ({w_addr, w_data, pc_data} !== 68'h0) begin fails++; $display("FAIL reset_data got %h/%h/%h want 0", w_addr, w_data, pc_data); end
    tests++; if (busy !== 16'h0) begin fails++; $display("FAIL reset_busy got %h want 0000", busy); end
    tests++; if (M !== 5'h13) begin fails++; $display("FAIL reset_M got %h want 13", M); end
    tests++; if (claim_ready !== 1'b1) begin fails++; $display("FAIL reset_claim_ready got %b want 1", claim_ready); end
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_round_robin;
    alu_req = 1; alu_addr = 3; alu_data = 32'h11;
    lsu_req = 1; lsu_addr = 4; lsu_data = 32'h22;
    #1;
    tests++; if ({alu_ready, lsu_ready} !== 2'b10) begin fails++; $display("FAIL rr_first_grant got %b want 10", {alu_ready, lsu_ready}); end
    tick;
    tests++; if ({write_reg, w_addr, w_data} !== {1'b1, 4'd3, 32'h11}) begin fails++; $display("FAIL rr_write_r3 got %b/%h/%h want 1/3/11", write_reg, w_addr, w_data); end
    alu_req = 0;
    #1;
    tests++; if (lsu_ready !== 1'b1) begin fails++; $display("FAIL rr_lsu_ready got %b want 1", lsu_ready); end
    tick;
    tests++; if ({write_reg, w_addr, w_data} !== {1'b1, 4'd4, 32'h22}) begin fails++; $display("FAIL rr_write_r4 got %b/%h/%h want 1/4/22", write_reg, w_addr, w_data); end
    lsu_req = 0;
    tick;
    tests++; if (write_reg !== 1'b0) begin fails++; $display("FAIL rr_pulse_end got %b want 0", write_reg); end
  endtask

  task automatic test_pc_contention;
    br_req = 1; br_data = 32'h100;
    alu_req = 1; alu_addr = 15; alu_data = 32'h200;
    #1;
    tests++; if ({br_ready, alu_ready} !== 2'b10) begin fails++; $display("FAIL pc_ready got %b want 10", {br_ready, alu_ready}); end
    tick;
    tests++; if ({write_pc, write_reg, pc_data} !== {2'b10, 32'h100}) begin fails++; $display("FAIL pc_branch got %b%b/%h want 10/100", write_pc, write_reg, pc_data); end
    br_req = 0;
    #1;
    tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL pc_alu_ready got %b want 1", alu_ready); end
    tick;
    tests++; if ({write_pc, write_reg, pc_data} !== {2'b10, 32'h200}) begin fails++; $display("FAIL pc_alu got %b%b/%h want 10/200", write_pc, write_reg, pc_data); end
    alu_req = 0;
    tick;
    tests++; if (write_pc !== 1'b0) begin fails++; $display("FAIL pc_pulse_end got %b want 0", write_pc); end
  endtask

  task automatic test_claim_collision;
    claim_valid = 1; claim_addr = 5;
    tick;
    tests++; if ({busy[5], claim_err} !== 2'b10) begin fails++; $display("FAIL claim_first got %b want 10", {busy[5], claim_err}); end
    alu_req = 1; alu_addr = 5; alu_data = 32'h55;
    tick;
    tests++; if ({busy[5], claim_err, write_reg} !== 3'b111) begin fails++; $display("FAIL claim_collide got %b want 111", {busy[5], claim_err, write_reg}); end
    claim_valid = 0;
    tick;
    tests++; if (busy !== 16'h0) begin fails++; $display("FAIL claim_recommit got %h want 0000", busy); end
    alu_req = 0;
    tick;
    tests++; if (claim_err !== 1'b1) begin fails++; $display("FAIL claim_sticky got %b want 1", claim_err); end
  endtask

  task automatic test_mode_change;
    claim_valid = 1; claim_addr = 2;
    tick;
    claim_valid = 0;
    tests++; if (busy !== 16'h0004) begin fails++; $display("FAIL mode_claim got %h want 0004", busy); end
    mode_req = 1; mode_new = 5'h10;
    tick;
    mode_req = 0; mode_new = 0;
    tests++; if ({claim_ready, mode_ack, M} !== {2'b00, 5'h13}) begin fails++; $display("FAIL mode_drain got %b%b/%h want 00/13", claim_ready, mode_ack, M); end
    mode_req = 1; mode_new = 5'h1A;
    tick;
    mode_req = 0; mode_new = 0;
    tests++; if (claim_ready !== 1'b0) begin fails++; $display("FAIL mode_hold got %b want 0", claim_ready); end
    alu_req = 1; alu_addr = 2; alu_data = 32'hAB;
    #1;
    tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL mode_wb_in_drain got %b want 1", alu_ready); end
    tick;
    alu_req = 0;
    tests++; if ({write_reg, w_addr, busy, mode_ack} !== {1'b1, 4'd2, 16'h0, 1'b0}) begin fails++; $display("FAIL mode_commit got %b/%h/%h/%b want 1/2/0000/0", write_reg, w_addr, busy, mode_ack); end
    tick;
    tests++; if ({mode_ack, M} !== {1'b0, 5'h13}) begin fails++; $display("FAIL mode_wait got %b/%h want 0/13", mode_ack, M); end
    tick;
    tests++; if ({mode_ack, M, claim_ready} !== {1'b1, 5'h10, 1'b0}) begin fails++; $display("FAIL mode_switch got %b/%h/%b want 1/10/0", mode_ack, M, claim_ready); end
    tick;
    tests++; if ({mode_ack, M, claim_ready} !== {1'b0, 5'h10, 1'b1}) begin fails++; $display("FAIL mode_idle got %b/%h/%b want 0/10/1", mode_ack, M, claim_ready); end
  endtask

  task automatic test_reset_drain;
    claim_valid = 1; claim_addr = 7;
    tick;
    claim_valid = 0;
    mode_req = 1; mode_new = 5'h1F;
    tick;
    mode_req = 0;
    alu_req = 1; alu_addr = 1; alu_data = 32'h77;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    tests++; if ({M, busy, write_reg} !== {5'h13, 16'h0, 1'b0}) begin fails++; $display("FAIL rst_async got %h/%h/%b want 13/0000/0", M, busy, write_reg); end
    tests++; if ({claim_err, claim_ready} !== 2'b01) begin fails++; $display("FAIL rst_state got %b want 01", {claim_err, claim_ready}); end
    alu_req = 0;
    tick;
    rst = 1'b0;
    tick;
    tests++; if ({write_reg, write_pc, mode_ack, M} !== {3'b000, 5'h13}) begin fails++; $display("FAIL rst_abandon got %b%b%b/%h want 000/13", write_reg, write_pc, mode_ack, M); end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_pc_contention;
    test_claim_collision;
    test_mode_change;
    test_reset_drain;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 Parameters SHALL be: AW, default 4, register address width; DW, default 32, data width; MW, default 5, processor mode width; PC_IDX, default 15, address that aliases the PC.
REQ-002 Ports SHALL be, as name  direction  width  meaning:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_req  in  1  ALU writeback valid.
- alu_addr  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- alu_ready  out  1  ALU writeback accepted this cycle.
- lsu_req  in  1  load-return valid.
- lsu_addr  in  AW  load destination register.
- lsu_data  in  DW  load data.
- lsu_ready  out  1  load writeback accepted this cycle.
- br_req  in  1  branch PC write valid.
- br_data  in  DW  branch target.
- br_ready  out  1  branch accepted this cycle.
- claim_valid  in  1  issue stage reserves a destination.
- claim_addr  in  AW  register being reserved.
- claim_ready  out  1  reservation accepted.
- mode_req  in  1  mode-change request.
- mode_new  in  MW  requested mode.
- mode_ack  out  1  one-cycle pulse when the mode is applied.
- w_addr  out  AW  register-file write address.
- w_data  out  DW  register-file write data.
- write_reg  out  1  register-file write enable.
- write_pc  out  1  PC write enable.
- pc_data  out  DW  PC write data.
- M  out  MW  mode presented to the register file.
- busy  out  2^AW  scoreboard of pending writes.
- claim_err  out  1  sticky flag: a register was claimed while already busy.

Function
REQ-003 A transfer SHALL occur when a requester's req and ready are both high in the same cycle; ready SHALL depend only on state and on the req inputs.
REQ-004 All register-file outputs SHALL be registered, so an accepted transfer appears on w_*/write_reg or pc_data/write_pc exactly 1 cycle after acceptance, as a single-cycle pulse.
REQ-005 ALU and LSU SHALL share the GPR port under round-robin arbitration: if both request, the source not granted last wins; the pointer SHALL favour ALU after reset and SHALL update only on a grant.
REQ-006 An ALU or LSU writeback to PC_IDX SHALL be routed to pc_data/write_pc, not write_reg, and SHALL compete for the PC port.
REQ-007 PC port priority SHALL be br_req first, then the GPR-arbitration winner targeting PC_IDX; a loser SHALL see ready=0 and hold its request.
REQ-008 In one cycle the block SHALL accept at most one GPR write and one PC write; both may be issued together.
REQ-009 A claim SHALL set busy[claim_addr] on acceptance, and a committed write SHALL clear busy[addr] at the cycle it is issued.
REQ-010 If a claim and a commit hit the same address in the same cycle, busy SHALL remain set.
REQ-011 A claim of an already-set busy bit SHALL be accepted and SHALL set claim_err, which stays high until reset.
REQ-012 The mode FSM SHALL have three states, IDLE, DRAIN and SWITCH, with these transitions:
- IDLE to DRAIN when mode_req is high.
- DRAIN to SWITCH when busy is zero and no write issue is pending in the output register.
- SWITCH to IDLE after 1 cycle, updating M to the mode_new value latched at the IDLE-to-DRAIN transition and pulsing mode_ack.
REQ-013 claim_ready SHALL be 0 in DRAIN and SWITCH and 1 in IDLE; writebacks SHALL continue to be accepted in DRAIN.
REQ-014 mode_req SHALL be ignored outside IDLE.

Reset
REQ-015 While rst is high, regardless of clk, the outputs SHALL be:
- write_reg, write_pc, mode_ack and claim_err at 0.
- w_addr, w_data and pc_data at 0.
- busy all zeros.
- M at 5'b10011 (supervisor mode).
- FSM in IDLE, round-robin pointer favouring ALU.
REQ-016 Reset mid-operation SHALL abandon any in-flight write without issuing it and SHALL abort DRAIN without changing M.

Structure
REQ-017 A shared package SHALL hold the FSM state enumeration, the reset mode constant MODE_SVC, and PC_IDX.
REQ-018 The two-way round-robin arbiter SHALL be a separate sub-module, rr_arb2.

Verification
REQ-019 Simultaneous requests: alu_req (r3 = 0x11) and lsu_req (r4 = 0x22) both held high SHALL produce a write of r3 (0x11) one cycle later, then r4 (0x22) the next cycle.
REQ-020 Same-cycle PC contention: br_req (0x100) and an ALU write to r15 (0x200) in the same cycle SHALL produce write_pc with 0x100 first and alu_ready=0 that cycle, then 0x200 on the following cycle.
REQ-021 Claim and commit collision: claim r5, then commit r5 while claiming r5 again SHALL leave busy[5]=1, with claim_err at 0 after the first claim and 1 after the second.
REQ-022 Mode change: claim r2, then mode_req with mode_new=0x10 SHALL keep the FSM in DRAIN with claim_ready=0 until r2 commits; then M=0x10 and mode_ack pulses 2 cycles after that commit.
REQ-023 Reset in DRAIN: asserting rst mid-DRAIN SHALL give M=0x13, busy=0 and write_reg=0 immediately, without waiting for a clock edge.
